instruction_fetch_unit: RTL

- Upstream stage of the datapath/control_unit pair.
- Holds the program counter and issues 32-bit instruction reads to instruction memory over a valid/ready request channel with a valid-only response channel.
- Buffers fetched instructions, each with its PC, in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Drives opcode to control_unit; honours redirects (branch/jump) by flushing.

---
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: holds the PC, issues single-outstanding reads to instruction
// memory and buffers {pc, instruction} pairs in a small FIFO feeding decode.
module instruction_fetch_unit #(
  parameter int                     WORDSIZE         = 64,
  parameter int                     INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0]    RESET_PC         = '0,
  parameter int                     FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          redirect_valid,
  input  logic [WORDSIZE-1:0]           redirect_pc,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [WORDSIZE-1:0]           imem_req_addr,
  input  logic                          imem_resp_valid,
  input  logic [INSTRUCTION_SIZE-1:0]   imem_resp_data,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [INSTRUCTION_SIZE-1:0]   inst_data,
  output logic [WORDSIZE-1:0]           inst_pc,
  output logic [6:0]                    opcode,
  output logic [1:0]                    dbg_state_o,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WORDSIZE-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [INSTRUCTION_SIZE-1:0] mem_data_q [FIFO_DEPTH];
  logic [WORDSIZE-1:0]         mem_pc_q   [FIFO_DEPTH];

  logic pop;
  logic push;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid, once raised, holds its payload until that edge (redirect excepted).
  // The response channel has no ready: each accepted request returns one pulse.
  assign inst_valid     = (count_q != '0);
  assign inst_data      = inst_valid ? mem_data_q[rd_ptr_q] : '0;
  assign inst_pc        = inst_valid ? mem_pc_q[rd_ptr_q] : '0;
  assign opcode         = inst_data[6:0];
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = fetch_pc_q;
  assign dbg_state_o    = state_q;
  assign dbg_count_o    = count_q;

  always_comb begin
    pop        = inst_valid & inst_ready;
    push       = (state_q == S_WAIT) & imem_resp_valid & ~redirect_valid;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fetch_pc_d = push ? fetch_pc_q + WORDSIZE'(4) : fetch_pc_q;
    state_d    = state_q;

    case (state_q)
      S_IDLE: if (count_q < DEPTH_C) state_d = S_REQ;
      S_REQ:  if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: if (imem_resp_valid) state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    // A redirect flushes everything; an already-accepted request must still drain.
    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc & ~WORDSIZE'(3);
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is not reset; the outputs are masked by inst_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= imem_resp_data;
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule
